gpio_mmio_responder: RTL and testbench
======================================

// Module: gpio_mmio_responder
// PURPOSE
//   Memory-mapped GPIO responder: the slave end of the CPU data-memory bus.
//   Decodes a 16-byte window at BASE_ADDR, holds the output latch that drives
//   GPIO_o, and synchronizes and debounces the GPIO_i pins.
//   Records rising/falling-edge flags (write-1-to-clear) and raises a masked
//   level interrupt. Sits beside Memory_System; the top level muxes Read_Data
//   on Sel_o.
// PARAMETERS
//   BASE_ADDR   32'h1001_0000  window base; bits [3:0] must be 0
//   GPIO_W      8              pin count, 1..16
//   DEB_CYCLES  4              debounce stability length in clk cycles, >=1
// PORTS
//   clk             in   1       rising-edge clock
//   reset           in   1       synchronous, active-low reset
//   Write_Enable_i  in   1       bus write strobe, qualified by Sel_o
//   Address_i       in   32      byte address from the CPU address mux
//   Write_Data      in   32      bus write data
//   Read_Data       out  32      combinational read data; 0 when Sel_o=0
//   Sel_o           out  1       Address_i[31:4]==BASE_ADDR[31:4] (combinational)
//   GPIO_i          in   GPIO_W  asynchronous input pins
//   GPIO_o          out  GPIO_W  output latch
//   irq_o           out  1       |(EDGE & {MASK,MASK}) (combinational)
// BEHAVIOUR
//   Register map, offset = Address_i[3:2]; Address_i[1:0] ignored; full-word access only:
//     0 OUT   RW  [GPIO_W-1:0] drives GPIO_o; upper bits read 0
//     1 IN    RO  debounced input value; writes ignored
//     2 EDGE  W1C [GPIO_W-1:0] rise flags, [GPIO_W+15:16] fall flags
//     3 MASK  RW  [GPIO_W-1:0] irq enable per pin (masks rise and fall)
//   Reset (reset==0 at a clk edge): OUT, IN, EDGE, MASK, sync1, sync2, cand and
//     cnt all go to 0. GPIO_o=0 and irq_o=0 from that edge. Reset mid-debounce
//     discards the pending value. The clear wins over every other action.
//   Writes take effect at the clk edge where Write_Enable_i && Sel_o.
//     GPIO_o shows the new OUT value after that edge.
//   Reads have no side effects. Read_Data is valid in the same cycle, so the
//     CPU data register captures it at the next edge.
//   Input path, per edge: sync1<=GPIO_i; sync2<=sync1; cand<=sync2;
//     cnt <= (sync2!=cand) ? 0 : (cnt==DEB_CYCLES-1 ? cnt : cnt+1);
//     commit when sync2==cand && cnt==DEB_CYCLES-1: IN<=cand.
//     The whole vector debounces together on one shared counter.
//   Latency: a pin change first sampled at edge 1 updates IN at edge DEB_CYCLES+3.
//     Pulses lasting <= DEB_CYCLES cycles never reach IN.
//     Pulses lasting >= DEB_CYCLES+1 cycles always reach IN.
//   Edge flags: on a commit, rise |= cand & ~IN and fall |= ~cand & IN. Flags are sticky.
//   W1C: a write to EDGE clears each bit where Write_Data has a 1.
//     If a set and a clear hit the same bit on the same edge, the set wins.
//   irq_o follows the flags and MASK combinationally; it stays high until software clears the flags.
//   Unselected or out-of-window accesses: no state change, Read_Data=0.
// TESTING
//   1 Reset: hold reset=0 for 2 clocks with GPIO_i=8'hFF.
//     -> GPIO_o=0, irq_o=0, all registers read 0.
//   2 Write 32'hA5 to BASE+0, then read BASE+0.
//     -> GPIO_o=8'hA5 the cycle after the write; Read_Data=32'h0000_00A5.
//   3 DEB_CYCLES=4; GPIO_i 0->8'h01 held.
//     -> IN=1 exactly at edge 7 after first sample; EDGE=32'h0000_0001.
//     -> With MASK=1, irq_o=1 at that same edge.
//   4 Glitch test: a 4-cycle pulse on GPIO_i[3] is rejected (IN/EDGE unchanged);
//     a 5-cycle pulse is accepted (rise then fall flags, 0x0008_0008).
//   5 W1C race: write 32'h1 to BASE+8 on the same edge a new rise on pin 0 commits
//     -> bit0 stays 1; a later write of 32'h1 clears it and drops irq_o.
//   6 Access to BASE+16 and a write to IN: no state change, Sel_o correct,
//     Read_Data=0 when unselected; assert reset mid-debounce -> no commit.

Source files
------------

// File: rtl/gpio_mmio_responder.sv
// Memory-mapped GPIO responder: 16-byte register window with an output latch,
// a synchronized and debounced input path, sticky edge flags and a masked irq.
module gpio_mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int unsigned GPIO_W     = 8,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Write_Enable_i,
    input  logic [31:0]       Address_i,
    input  logic [31:0]       Write_Data,
    output logic [31:0]       Read_Data,
    output logic              Sel_o,
    input  logic [GPIO_W-1:0] GPIO_i,
    output logic [GPIO_W-1:0] GPIO_o,
    output logic              irq_o
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam int unsigned FALL_LSB = 16;

    localparam logic [1:0] OFF_OUT  = 2'd0;
    localparam logic [1:0] OFF_IN   = 2'd1;
    localparam logic [1:0] OFF_EDGE = 2'd2;
    localparam logic [1:0] OFF_MASK = 2'd3;

    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] in_q, in_d;
    logic [GPIO_W-1:0] rise_q, rise_d;
    logic [GPIO_W-1:0] fall_q, fall_d;
    logic [GPIO_W-1:0] mask_q, mask_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q, cand_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]  offset;
    logic        wr_en;
    logic        commit;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign offset = Address_i[3:2];
    assign Sel_o  = (Address_i[31:4] == BASE_ADDR[31:4]);
    assign wr_en  = Write_Enable_i && Sel_o;
    assign commit = (sync2_q == cand_q) && (cnt_q == CNT_MAX);
    assign GPIO_o = out_q;
    assign irq_o  = |((rise_q | fall_q) & mask_q);

    // Byte-lane bits and bus bits above the pin range carry no state.
    assign unused_bits = &{1'b0, Address_i[1:0], Write_Data};

    // Next-state: bus writes, debounce counter, commit and edge flags (set beats W1C).
    always_comb begin
        out_d  = out_q;
        in_d   = in_q;
        rise_d = rise_q;
        fall_d = fall_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;

        if (wr_en && offset == OFF_OUT)  out_d  = Write_Data[GPIO_W-1:0];
        if (wr_en && offset == OFF_MASK) mask_d = Write_Data[GPIO_W-1:0];
        if (wr_en && offset == OFF_EDGE) begin
            rise_d = rise_d & ~Write_Data[GPIO_W-1:0];
            fall_d = fall_d & ~Write_Data[FALL_LSB +: GPIO_W];
        end

        if (sync2_q != cand_q)      cnt_d = '0;
        else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CNT_W'(1);

        if (commit) begin
            in_d   = cand_q;
            rise_d = rise_d | (cand_q & ~in_q);
            fall_d = fall_d | (~cand_q & in_q);
        end
    end

    // Read mux; zero whenever the window is not selected.
    always_comb begin
        rd_word = '0;
        case (offset)
            OFF_OUT:  rd_word[GPIO_W-1:0] = out_q;
            OFF_IN:   rd_word[GPIO_W-1:0] = in_q;
            OFF_EDGE: begin
                rd_word[GPIO_W-1:0]          = rise_q;
                rd_word[FALL_LSB +: GPIO_W]  = fall_q;
            end
            default:  rd_word[GPIO_W-1:0] = mask_q;
        endcase
        Read_Data = Sel_o ? rd_word : 32'h0;
    end

    // State registers with synchronous active-low clear that overrides everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q   <= '0;
            in_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            mask_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d;
            in_q    <= in_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            mask_q  <= mask_d;
            sync1_q <= GPIO_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gpio_mmio_responder.sv
// Directed self-checking bench for gpio_mmio_responder.
module tb_gpio_mmio_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk;
    logic        reset;
    logic        Write_Enable_i;
    logic [31:0] Address_i;
    logic [31:0] Write_Data;
    logic [31:0] Read_Data;
    logic        Sel_o;
    logic [7:0]  GPIO_i;
    logic [7:0]  GPIO_o;
    logic        irq_o;

    int total;
    int bad;

    gpio_mmio_responder #(
        .BASE_ADDR (BASE),
        .GPIO_W    (8),
        .DEB_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Write_Enable_i(Write_Enable_i),
        .Address_i     (Address_i),
        .Write_Data    (Write_Data),
        .Read_Data     (Read_Data),
        .Sel_o         (Sel_o),
        .GPIO_i        (GPIO_i),
        .GPIO_o        (GPIO_o),
        .irq_o         (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 time unit after the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Address_i      = addr;
        Write_Data     = data;
        Write_Enable_i = 1'b1;
        tick(1);
        Write_Enable_i = 1'b0;
        Write_Data     = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        Address_i      = addr;
        Write_Enable_i = 1'b0;
        #1;
        data = Read_Data;
    endtask

    logic [31:0] rd;

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b0;
        Write_Enable_i = 1'b0;
        Address_i      = BASE;
        Write_Data     = 32'h0;
        GPIO_i         = 8'hFF;

        // 1: reset held two clocks with all pins high
        #2;
        tick(2);
        check("rst_gpio_o", 32'(GPIO_o), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        bus_read(BASE + 32'h0, rd); check("rst_out", rd, 32'h0);
        bus_read(BASE + 32'h4, rd); check("rst_in", rd, 32'h0);
        bus_read(BASE + 32'h8, rd); check("rst_edge", rd, 32'h0);
        bus_read(BASE + 32'hC, rd); check("rst_mask", rd, 32'h0);
        GPIO_i = 8'h00;
        reset  = 1'b1;
        tick(2);

        // 2: output latch write/readback
        bus_write(BASE + 32'h0, 32'h0000_00A5);
        check("out_gpio_o", 32'(GPIO_o), 32'h0000_00A5);
        bus_read(BASE + 32'h0, rd);
        check("out_read", rd, 32'h0000_00A5);
        check("out_sel", 32'(Sel_o), 32'h1);

        // 3: debounce latency, edge flag, irq
        bus_write(BASE + 32'hC, 32'h1);
        Address_i = BASE + 32'h4;
        GPIO_i    = 8'h01;
        tick(6);
        check("deb_in_e6", Read_Data, 32'h0);
        check("deb_irq_e6", 32'(irq_o), 32'h0);
        tick(1);
        check("deb_in_e7", Read_Data, 32'h1);
        check("deb_irq_e7", 32'(irq_o), 32'h1);
        bus_read(BASE + 32'h8, rd);
        check("deb_edge", rd, 32'h0000_0001);
        bus_write(BASE + 32'h8, 32'h1);
        check("deb_clr_irq", 32'(irq_o), 32'h0);

        // 4: 4-cycle glitch on pin 3 rejected, 5-cycle pulse accepted
        GPIO_i = 8'h09;
        tick(4);
        GPIO_i = 8'h01;
        tick(12);
        bus_read(BASE + 32'h4, rd); check("glitch4_in", rd, 32'h1);
        bus_read(BASE + 32'h8, rd); check("glitch4_edge", rd, 32'h0);
        GPIO_i = 8'h09;
        tick(5);
        GPIO_i = 8'h01;
        tick(15);
        bus_read(BASE + 32'h4, rd); check("pulse5_in", rd, 32'h1);
        bus_read(BASE + 32'h8, rd); check("pulse5_edge", rd, 32'h0008_0008);
        check("pulse5_irq_masked", 32'(irq_o), 32'h0);
        bus_write(BASE + 32'h8, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h8, rd); check("w1c_all", rd, 32'h0);

        // 5: W1C racing a new rise on pin 0 (set wins)
        GPIO_i = 8'h00;
        tick(10);
        bus_read(BASE + 32'h8, rd); check("fall0_edge", rd, 32'h0001_0000);
        check("fall0_irq", 32'(irq_o), 32'h1);
        bus_write(BASE + 32'h8, 32'h0001_0000);
        check("fall0_clr_irq", 32'(irq_o), 32'h0);
        GPIO_i = 8'h01;
        tick(6);
        bus_write(BASE + 32'h8, 32'h1);
        bus_read(BASE + 32'h8, rd); check("race_edge", rd, 32'h1);
        check("race_irq", 32'(irq_o), 32'h1);
        bus_write(BASE + 32'h8, 32'h1);
        bus_read(BASE + 32'h8, rd); check("race_clr_edge", rd, 32'h0);
        check("race_clr_irq", 32'(irq_o), 32'h0);

        // 6: out-of-window and read-only accesses, then reset mid-debounce
        bus_write(BASE + 32'h10, 32'h0000_0055);
        Address_i = BASE + 32'h10;
        #1;
        check("oow_sel", 32'(Sel_o), 32'h0);
        check("oow_read", Read_Data, 32'h0);
        check("oow_gpio_o", 32'(GPIO_o), 32'h0000_00A5);
        bus_read(BASE + 32'hC, rd); check("oow_mask", rd, 32'h1);
        bus_write(BASE + 32'h4, 32'h0000_00FF);
        bus_read(BASE + 32'h4, rd); check("ro_in", rd, 32'h1);
        GPIO_i = 8'h00;
        tick(4);
        reset = 1'b0;
        tick(1);
        check("midrst_gpio_o", 32'(GPIO_o), 32'h0);
        bus_read(BASE + 32'h4, rd); check("midrst_in", rd, 32'h0);
        reset = 1'b1;
        tick(10);
        bus_read(BASE + 32'h8, rd); check("midrst_edge", rd, 32'h0);
        bus_read(BASE + 32'h4, rd); check("midrst_in_after", rd, 32'h0);
        check("midrst_irq", 32'(irq_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
